// File: rtl/tlul_ram_gen.sv
// TL-UL attached single-port RAM with byte-masked writes, ReadLatency-deep read pipeline and an
// in-order response FIFO; define TLUL_RAM_PARITY_EN to store and check per-lane even parity.
package tlul_pkg;
   localparam logic [2:0] OpPutFull      = 3'd0;
   localparam logic [2:0] OpPutPartial   = 3'd1;
   localparam logic [2:0] OpGet          = 3'd4;
   localparam logic [2:0] OpAccessAck     = 3'd0;
   localparam logic [2:0] OpAccessAckData = 3'd1;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;
endpackage

module tlul_ram_gen
   import tlul_pkg::*;
#(
   parameter int AddrWidth   = 12,
   parameter int DataWidth   = 32,
   parameter int ReadLatency = 1,
   parameter int Outstanding = 2,
   parameter int ErrOnWrite  = 0
) (
   input  logic    clock,
   input  logic    reset,
   input  tl_h2d_t tl_d_i,
   output tl_d2h_t tl_d_o
);
   localparam int NB   = DataWidth / 8;
   localparam int OffW = (NB > 1) ? $clog2(NB) : 0;
`ifdef TLUL_RAM_PARITY_EN
   localparam int MemW = DataWidth + NB;
`else
   localparam int MemW = DataWidth;
`endif
   localparam logic [2:0] OutMax  = 3'(Outstanding);
   localparam logic [1:0] LastPtr = 2'(Outstanding - 1);

   typedef struct packed {
      logic                 err;
      logic                 rd;
      logic [1:0]           size;
      logic [7:0]           source;
      logic [DataWidth-1:0] data;
   } rsp_t;

   logic [MemW-1:0] mem [2**AddrWidth];

   logic [AddrWidth-1:0] idx;
   logic [NB-1:0]        mask;
   logic                 addr_err, is_get, is_put, op_err, req_err;
   logic                 a_ready, accept, retire, we, par_bad, push, d_valid;
   logic [MemW-1:0]      rd_word;
   rsp_t                 pipe_in, push_dat, head;
   rsp_t                 fifo_q [4];
   logic [1:0]           wptr_q, rptr_q;
   logic [2:0]           cnt_q, cnt_d, inflight_q, inflight_d;

   logic unused_ok;
   assign unused_ok = ^{tl_d_i.a_param};

   assign idx      = tl_d_i.a_address[AddrWidth+OffW-1:OffW];
   assign mask     = tl_d_i.a_mask[NB-1:0];
   assign addr_err = |(tl_d_i.a_address >> (AddrWidth + OffW));
   assign is_get   = tl_d_i.a_opcode == OpGet;
   assign is_put   = tl_d_i.a_opcode == OpPutFull || tl_d_i.a_opcode == OpPutPartial;
   assign op_err   = !(is_get || is_put)
                   || (tl_d_i.a_opcode == OpPutFull && mask != '1)
                   || (is_put && ErrOnWrite != 0);
   assign req_err  = addr_err | op_err;

   assign a_ready  = inflight_q < OutMax;
   assign accept   = tl_d_i.a_valid & a_ready;
   assign d_valid  = cnt_q != 3'd0;
   assign retire   = d_valid & tl_d_i.d_ready;
   assign we       = accept & is_put & ~req_err;
   assign rd_word  = mem[idx];

   always_comb begin
      par_bad = 1'b0;
`ifdef TLUL_RAM_PARITY_EN
      for (int b = 0; b < NB; b++) par_bad |= ^{rd_word[DataWidth+b], rd_word[b*8 +: 8]};
`endif
      pipe_in        = '0;
      pipe_in.err    = req_err | (is_get & par_bad);
      pipe_in.rd     = is_get;
      pipe_in.size   = tl_d_i.a_size;
      pipe_in.source = tl_d_i.a_source;
      pipe_in.data   = (is_get & ~req_err) ? rd_word[DataWidth-1:0] : '0;
   end

   // Write commits at the accept edge, so a Get on the following cycle sees it without bypass.
   always_ff @(posedge clock) begin
      if (we) begin
         for (int b = 0; b < NB; b++) begin
            if (mask[b]) begin
               mem[idx][b*8 +: 8] <= tl_d_i.a_data[b*8 +: 8];
`ifdef TLUL_RAM_PARITY_EN
               mem[idx][DataWidth+b] <= ^tl_d_i.a_data[b*8 +: 8];
`endif
            end
         end
      end
   end

   // The FIFO write is the last latency stage; only ReadLatency-1 extra registers sit before it.
   if (ReadLatency == 1) begin : g_nopipe
      assign push     = accept;
      assign push_dat = pipe_in;
   end else begin : g_pipe
      logic [ReadLatency-2:0] vld_q;
      rsp_t                   dat_q [ReadLatency-1];
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            vld_q <= '0;
            for (int s = 0; s < ReadLatency - 1; s++) dat_q[s] <= '0;
         end else begin
            vld_q[0] <= accept;
            dat_q[0] <= pipe_in;
            for (int s = 1; s < ReadLatency - 1; s++) begin
               vld_q[s] <= vld_q[s-1];
               dat_q[s] <= dat_q[s-1];
            end
         end
      end
      assign push     = vld_q[ReadLatency-2];
      assign push_dat = dat_q[ReadLatency-2];
   end

   always_comb begin
      inflight_d = inflight_q;
      if (accept && !retire) inflight_d = inflight_q + 3'd1;
      if (!accept && retire) inflight_d = inflight_q - 3'd1;
      cnt_d = cnt_q;
      if (push && !retire) cnt_d = cnt_q + 3'd1;
      if (!push && retire) cnt_d = cnt_q - 3'd1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int e = 0; e < 4; e++) fifo_q[e] <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         inflight_q <= '0;
      end else begin
         if (push) begin
            fifo_q[wptr_q] <= push_dat;
            wptr_q         <= (wptr_q == LastPtr) ? 2'd0 : wptr_q + 2'd1;
         end
         if (retire) rptr_q <= (rptr_q == LastPtr) ? 2'd0 : rptr_q + 2'd1;
         cnt_q      <= cnt_d;
         inflight_q <= inflight_d;
      end
   end

   assign head = fifo_q[rptr_q];

   always_comb begin
      tl_d_o         = '0;
      tl_d_o.a_ready = a_ready;
      tl_d_o.d_valid = d_valid;
      if (d_valid) begin
         tl_d_o.d_opcode = head.rd ? OpAccessAckData : OpAccessAck;
         tl_d_o.d_size   = head.size;
         tl_d_o.d_source = head.source;
         tl_d_o.d_data   = 32'(head.data);
         tl_d_o.d_error  = head.err;
      end
   end
endmodule

// File: tb/tb_tlul_ram_gen.sv
// Directed bench for tlul_ram_gen with default parameters (ReadLatency=1, Outstanding=2).
module tb_tlul_ram_gen;
   import tlul_pkg::*;

   logic    clk = 1'b0;
   logic    rst_n;
   tl_h2d_t h2d;
   tl_d2h_t d2h;
   int      checks = 0;
   int      failures = 0;

   logic        r_vld, r_err;
   logic [2:0]  r_op;
   logic [7:0]  r_src;
   logic [31:0] r_data;

   always #5 clk = ~clk;

   tlul_ram_gen dut (
      .clock  (clk),
      .reset  (rst_n),
      .tl_d_i (h2d),
      .tl_d_o (d2h)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one request and sample the D channel on the first negedge after the accept edge.
   task automatic xact(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] data, input logic [7:0] src);
      h2d.a_valid   = 1'b1;
      h2d.a_opcode  = op;
      h2d.a_address = addr;
      h2d.a_mask    = mask;
      h2d.a_data    = data;
      h2d.a_source  = src;
      h2d.a_size    = 2'd2;
      for (int i = 0; i < 50 && !d2h.a_ready; i++) @(negedge clk);
      chk("a_ready_wait", {31'd0, d2h.a_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      h2d.a_valid = 1'b0;
      r_vld  = d2h.d_valid;
      r_err  = d2h.d_error;
      r_op   = d2h.d_opcode;
      r_src  = d2h.d_source;
      r_data = d2h.d_data;
   endtask

   task automatic idle();
      h2d.a_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      h2d = '0;
      h2d.d_ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_d_valid", {31'd0, d2h.d_valid}, 32'd0);
      chk("rst_d_error", {31'd0, d2h.d_error}, 32'd0);
      chk("rst_d_data", d2h.d_data, 32'd0);
      chk("rst_d_opcode", {29'd0, d2h.d_opcode}, 32'd0);
      chk("rst_d_source", {24'd0, d2h.d_source}, 32'd0);
      chk("rst_d_size", {30'd0, d2h.d_size}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_a_ready", {31'd0, d2h.a_ready}, 32'd1);

      xact(3'd0, 32'h10, 4'hF, 32'hDEADBEEF, 8'd3);
      chk("put_vld", {31'd0, r_vld}, 32'd1);
      chk("put_op", {29'd0, r_op}, 32'd0);
      chk("put_src", {24'd0, r_src}, 32'd3);
      chk("put_err", {31'd0, r_err}, 32'd0);
      chk("put_data", r_data, 32'd0);
      idle();
      chk("put_retired", {31'd0, d2h.d_valid}, 32'd0);

      xact(3'd4, 32'h10, 4'hF, 32'd0, 8'd1);
      chk("get_vld", {31'd0, r_vld}, 32'd1);
      chk("get_op", {29'd0, r_op}, 32'd1);
      chk("get_data", r_data, 32'hDEADBEEF);
      chk("get_src", {24'd0, r_src}, 32'd1);

      xact(3'd1, 32'h10, 4'h2, 32'h0000AA00, 8'd2);
      chk("ppart_err", {31'd0, r_err}, 32'd0);
      xact(3'd4, 32'h10, 4'hF, 32'd0, 8'd2);
      chk("ppart_data", r_data, 32'hDEADAAEF);

      xact(3'd4, 32'h4000, 4'hF, 32'd0, 8'd6);
      chk("addr_err", {31'd0, r_err}, 32'd1);
      chk("addr_err_data", r_data, 32'd0);
      chk("addr_err_src", {24'd0, r_src}, 32'd6);
      xact(3'd5, 32'h10, 4'hF, 32'h0, 8'd7);
      chk("op5_err", {31'd0, r_err}, 32'd1);
      xact(3'd0, 32'h10, 4'h7, 32'h11111111, 8'd8);
      chk("pfull_mask_err", {31'd0, r_err}, 32'd1);
      xact(3'd0, 32'h4010, 4'hF, 32'h22222222, 8'd9);
      chk("put_addr_err", {31'd0, r_err}, 32'd1);
      xact(3'd4, 32'h10, 4'hF, 32'd0, 8'd10);
      chk("mem_unchanged_err", {31'd0, r_err}, 32'd0);
      chk("mem_unchanged", r_data, 32'hDEADAAEF);
      idle();

      h2d.d_ready   = 1'b0;
      h2d.a_valid   = 1'b1;
      h2d.a_opcode  = 3'd4;
      h2d.a_address = 32'h10;
      h2d.a_mask    = 4'hF;
      h2d.a_source  = 8'd0;
      chk("bp_ready0", {31'd0, d2h.a_ready}, 32'd1);
      @(posedge clk); @(negedge clk);
      h2d.a_source = 8'd1;
      chk("bp_ready1", {31'd0, d2h.a_ready}, 32'd1);
      @(posedge clk); @(negedge clk);
      h2d.a_source = 8'd2;
      chk("bp_ready_drop", {31'd0, d2h.a_ready}, 32'd0);
      chk("bp_head_src0", {24'd0, d2h.d_source}, 32'd0);
      repeat (2) begin @(posedge clk); @(negedge clk); end
      chk("bp_held_ready", {31'd0, d2h.a_ready}, 32'd0);
      chk("bp_held_vld", {31'd0, d2h.d_valid}, 32'd1);
      chk("bp_held_src0", {24'd0, d2h.d_source}, 32'd0);
      h2d.d_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("bp_rsp_src1", {24'd0, d2h.d_source}, 32'd1);
      chk("bp_ready_back", {31'd0, d2h.a_ready}, 32'd1);
      @(posedge clk); @(negedge clk);
      h2d.a_valid = 1'b0;
      chk("bp_third_vld", {31'd0, d2h.d_valid}, 32'd1);
      chk("bp_third_src", {24'd0, d2h.d_source}, 32'd2);
      chk("bp_third_data", d2h.d_data, 32'hDEADAAEF);
      idle();

      xact(3'd0, 32'h20, 4'hF, 32'h12345678, 8'd4);
      chk("b2b_put_src", {24'd0, r_src}, 32'd4);
      xact(3'd4, 32'h20, 4'hF, 32'd0, 8'd5);
      chk("b2b_get_data", r_data, 32'h12345678);
      chk("b2b_get_op", {29'd0, r_op}, 32'd1);

      for (int i = 0; i < 8; i++) begin
         h2d.a_valid   = 1'b1;
         h2d.a_opcode  = 3'd4;
         h2d.a_address = 32'h20;
         h2d.a_source  = 8'(16 + i);
         chk("stream_ready", {31'd0, d2h.a_ready}, 32'd1);
         @(posedge clk); @(negedge clk);
         chk("stream_vld", {31'd0, d2h.d_valid}, 32'd1);
         chk("stream_src", {24'd0, d2h.d_source}, 32'(16 + i));
      end
      idle();

      h2d.d_ready = 1'b0;
      h2d.a_valid = 1'b1;
      h2d.a_source = 8'd30;
      @(posedge clk); @(negedge clk);
      h2d.a_source = 8'd31;
      @(posedge clk); @(negedge clk);
      h2d.a_valid = 1'b0;
      chk("mid_pre_vld", {31'd0, d2h.d_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", {31'd0, d2h.d_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      h2d.d_ready = 1'b1;
      @(negedge clk);
      chk("mid_rel_ready", {31'd0, d2h.a_ready}, 32'd1);
      repeat (3) begin @(posedge clk); @(negedge clk); end
      chk("mid_no_beat", {31'd0, d2h.d_valid}, 32'd0);
      xact(3'd4, 32'h20, 4'hF, 32'd0, 8'd12);
      chk("mid_mem_kept", r_data, 32'h12345678);
      chk("mid_mem_src", {24'd0, r_src}, 32'd12);

`ifdef TLUL_RAM_PARITY_EN
      idle();
      dut.mem[8][0] = ~dut.mem[8][0];
      xact(3'd4, 32'h20, 4'hF, 32'd0, 8'd13);
      chk("par_err", {31'd0, r_err}, 32'd1);
      chk("par_raw_data", r_data, 32'h12345679);
`endif
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/tlul_ram_gen.md
Name: tlul_ram_gen

Overview:
- Parametrised TL-UL attached single-port RAM: generalised successor of the fixed 4 KiB-word instruction memory.
- Internal storage array with byte-masked writes and a configurable read pipeline depth (1..3 cycles).
- Configurable number of outstanding requests, backed by an in-order response FIFO, so the D channel tolerates `d_ready` backpressure without losing data.
- Sits on the TL-UL crossbar as an instruction or data memory device.

Parameters:
- AddrWidth, 12, word-address bits; depth = 2**AddrWidth words.
- DataWidth, 32, data bits; must be a multiple of 8; byte lanes = DataWidth/8.
- ReadLatency, 1, cycles from A accept to read data valid; legal 1..3.
- Outstanding, 2, maximum accepted-but-unretired requests; legal 1..4.
- ErrOnWrite, 0, 1: all Put* opcodes return `d_error` and leave memory unchanged.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous active-low reset
- tl_d_i  input  tlul_pkg::tl_h2d_t  TL-UL A channel plus `d_ready` from host
- tl_d_o  output  tlul_pkg::tl_d2h_t  TL-UL D channel plus `a_ready` to host

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset values:
  - `d_valid`=0, `d_error`=0, `d_data`=0, `d_source`=0, `d_opcode`=AccessAck, `d_size`=0.
  - Inflight count=0, FIFO empty, read pipeline flushed.
  - `a_ready`=1 in the first cycle after reset release.
  - Memory contents are not reset.
- Acceptance:
  - `a_ready` = (inflight < Outstanding), registered-free combinational.
  - Accept when `a_valid` & `a_ready`.
  - Inflight increments on accept and decrements on D handshake (`d_valid` & `d_ready`).
  - Simultaneous accept and retire leaves the count unchanged.
- Word index = `a_address[AddrWidth+1:2]` (for DataWidth=32; in general the byte-offset bits are log2(DataWidth/8)).
- Address error: any set bit of `a_address` above the word index bits.
- Opcodes:
  - Get(4): read the word at the accept edge; result enters the read pipeline.
  - PutFullData(0) and PutPartialData(1): write byte lanes where `a_mask`=1, at the accept edge.
  - PutFullData with a mask other than all-ones is an error.
  - Any other opcode is an error.
- Error requests:
  - Memory is not written.
  - Response `d_error`=1 and `d_data`=0.
  - The response still traverses the same latency path, so ordering is preserved.
- Response:
  - `d_opcode` = AccessAckData for Get, AccessAck for Put.
  - `d_size` and `d_source` are echoed from the A request.
  - `d_data` = read data for Get, 0 for Put.
- Pipeline:
  - Request metadata (opcode, size, source, error) shifts alongside the data through ReadLatency stages.
  - The stage output pushes into a response FIFO of depth Outstanding.
  - The FIFO never overflows because `a_ready` gating guarantees space.
- D channel:
  - `d_valid` = FIFO non-empty; the head holds stable until `d_ready`.
  - Best-case latency: accept at cycle N gives `d_valid` at N+ReadLatency.
- Read-after-write: a Get accepted the cycle after a Put to the same word returns the new data. Back-to-back accesses need no bypass, because the write commits at the accept edge.
- Full throughput: one request per cycle while `d_ready`=1 and Outstanding ≥ ReadLatency+1.
- Reset mid-operation: in-flight and queued responses are discarded and no D beat is emitted for them. Writes already committed remain.

Optional Feature:
- Macro: TLUL_RAM_PARITY_EN.
- With the macro defined:
  - One even-parity bit is stored per byte lane and written with the data.
  - On Get, any lane parity mismatch sets `d_error`=1; `d_data` still returns the raw word.
  - Lanes written by PutPartialData regenerate only their own parity bits.
  - Memory width is DataWidth + DataWidth/8.
- Without the macro: no parity storage; `d_error` arises only from address, opcode and write errors.

Test Plan:
- Reset, then PutFullData addr 0x10, mask 0xF, data 0xDEADBEEF, source 3 -> AccessAck, `d_source`=3, `d_error`=0; then Get 0x10 -> AccessAckData, `d_data`=0xDEADBEEF, arriving ReadLatency cycles after accept.
- PutPartialData addr 0x10, mask 0x2, data 0x0000AA00 over 0xDEADBEEF -> subsequent Get returns 0xDEADAAEF.
- Get at 0x4000 with AddrWidth=12 -> `d_error`=1, `d_data`=0; opcode 5 -> `d_error`=1; memory unchanged.
- Hold `d_ready`=0 and issue 3 Gets with Outstanding=2 -> `a_ready` drops after 2 accepts; release `d_ready` -> responses in order with sources 0,1, then the third is accepted.
- Back-to-back Put 0x20=0x12345678, Get 0x20 on consecutive cycles, `d_ready`=1 -> Get returns 0x12345678; sustained 8 Gets give one `d_valid` per cycle.
- Assert reset with 2 requests in flight -> `d_valid`=0 immediately and `a_ready`=1 after release; with TLUL_RAM_PARITY_EN, force a flipped stored bit -> Get returns `d_error`=1.
